// File: rtl/mux_arbiter.sv
// Packet-level round-robin arbiter for the router's 2:1 output mux.
// A port owns the mux from its HEAD flit through its TAIL flit (wormhole lock).
module mux_arbiter #(
    parameter int          TYPEW     = 2,
    parameter int          SELW      = 5,
    parameter logic [TYPEW-1:0] TYPE_NONE = 2'b00,
    parameter logic [TYPEW-1:0] TYPE_HEAD = 2'b01,
    parameter logic [TYPEW-1:0] TYPE_DATA = 2'b10,
    parameter logic [TYPEW-1:0] TYPE_TAIL = 2'b11,
    parameter int          CNTW      = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             ivalid_0,
    input  logic [TYPEW-1:0] itype_0,
    input  logic             ivalid_1,
    input  logic [TYPEW-1:0] itype_1,
    input  logic             ordy,
    output logic [SELW-1:0]  sel,
    output logic             gnt_0,
    output logic             gnt_1,
    output logic             busy,
    output logic [CNTW-1:0]  pkt_cnt_0,
    output logic [CNTW-1:0]  pkt_cnt_1,
    output logic             err
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;
    logic              ptr_reg, ptr_next;
    logic              head_done_reg, head_done_next;
    logic              err_reg, err_next;
    logic [SELW-1:0]   sel_reg, sel_next;
    logic [CNTW-1:0]   cnt_reg [2];
    logic [1:0]        cnt_inc;

    logic [1:0]        ivalid;
    logic [TYPEW-1:0]  itype [2];
    logic [1:0]        gnt;
    logic [1:0]        req;
    logic              owner_gnt;
    logic [TYPEW-1:0]  owner_type;

    assign ivalid   = {ivalid_1, ivalid_0};
    assign itype[0] = itype_0;
    assign itype[1] = itype_1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            // A valid TYPE_NONE flit is never granted, even by the owner.
            assign gnt[gi] = sel_reg[gi] & ivalid[gi] & ordy & (itype[gi] != TYPE_NONE);
            assign req[gi] = ivalid[gi] & (itype[gi] == TYPE_HEAD);

            always_ff @(posedge clk or negedge rst_) begin
                if (!rst_) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi]) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign owner_gnt  = gnt[owner_reg];
    assign owner_type = itype[owner_reg];

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        ptr_next       = ptr_reg;
        head_done_next = head_done_reg;
        err_next       = err_reg;
        sel_next       = sel_reg;
        cnt_inc        = '0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next     = LOCK;
                    head_done_next = 1'b0;
                    owner_next     = (req == 2'b11) ? ptr_reg : req[1];
                    sel_next       = {{(SELW-2){1'b0}}, owner_next, ~owner_next};
                end
            end
            LOCK: begin
                if (owner_gnt) begin
                    head_done_next = 1'b1;
                    case (owner_type)
                        TYPE_TAIL: begin
                            state_next        = IDLE;
                            sel_next          = '0;
                            ptr_next          = ~owner_reg;
                            cnt_inc[owner_reg] = 1'b1;
                        end
                        // A second HEAD inside a packet is passed through as DATA but flagged.
                        TYPE_HEAD: begin
                            if (head_done_reg) begin
                                err_next = 1'b1;
                            end
                        end
                        TYPE_DATA: begin
                        end
                        default: begin
                        end
                    endcase
                end
            end
            default: begin
                state_next = IDLE;
                sel_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_reg     <= IDLE;
            owner_reg     <= 1'b0;
            ptr_reg       <= 1'b0;
            head_done_reg <= 1'b0;
            err_reg       <= 1'b0;
            sel_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            ptr_reg       <= ptr_next;
            head_done_reg <= head_done_next;
            err_reg       <= err_next;
            sel_reg       <= sel_next;
        end
    end

    assign sel       = sel_reg;
    assign gnt_0     = gnt[0];
    assign gnt_1     = gnt[1];
    assign busy      = (state_reg == LOCK);
    assign pkt_cnt_0 = cnt_reg[0];
    assign pkt_cnt_1 = cnt_reg[1];
    assign err       = err_reg;

endmodule
